// File: rtl/ysyx_lsu_bus_bridge.sv
// ---------------------------------------------------------------------------
// ysyx_lsu_bus_bridge
//
// Purpose:
//   Turns the LSU's level-held load/store requests into single AXI4-Lite-style
//   master transactions, one outstanding at a time.
//   - Loads: the full byte address and a transfer size are sent on AR. The raw
//     32-bit bus word comes back on lsu_rdata. The LSU does its own
//     right-shift and sign extension.
//   - Stores: the LSB-aligned store data and the byte strobe are shifted onto
//     the correct byte lanes before they are sent on AW/W.
//
// Optional feature (compile-time macro YSYX_LSU_BRIDGE_ALIGN_CHECK_EN):
//   Defined:
//     Misaligned halfword/word requests are rejected in IDLE. They go straight
//     to the completion pulse with lsu_err=1 and never touch the bus.
//     A misaligned load returns lsu_rdata=0.
//   Undefined:
//     Every request is issued as-is. Lane steering is simply truncated to the
//     4 byte lanes.
//
// Ports:
//   clk, rst        : clock; synchronous active-high reset
//   lsu_ar*         : load request (address, size strobe, level-held valid)
//   lsu_aw*, lsu_w* : store request (address, data, size strobe, valids)
//   lsu_rdata       : raw bus word from the last completed read
//   lsu_rvalid      : one-cycle load-completion pulse
//   lsu_wready      : one-cycle store-completion pulse
//   lsu_err         : error flag, valid together with the completion pulse
//   ar*/r*          : AXI4-Lite-style read address and read data channels
//   aw*/w*/b*       : AXI4-Lite-style write address, write data and response
//
// All outputs are registered. No bus input reaches an output combinationally.
// ---------------------------------------------------------------------------
module ysyx_lsu_bus_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // LSU side
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  input  logic              lsu_wvalid,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  output logic              lsu_wready,
  output logic              lsu_err,
  // Read address channel
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  // Read data channel
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  // Write address channel
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  // Write data channel
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  // Write response channel
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR_A,
    WR_B,
    RESP,
    HOLD
  } state_t;

  state_t state_reg;

  // Strobe to AXI size.
  // Any strobe that is not a byte or a halfword is treated as a full word.
  function automatic logic [2:0] strb_to_size(input logic [7:0] strb);
    logic [2:0] size;
    case (strb)
      8'h01:   size = 3'd0;
      8'h03:   size = 3'd1;
      default: size = 3'd2;
    endcase
    return size;
  endfunction

  logic [2:0] rd_size;
  logic [2:0] wr_size;
  assign rd_size = strb_to_size(lsu_rstrb);
  assign wr_size = strb_to_size(lsu_wstrb);

  // Store lane steering.
  // The data and the strobe move up by the byte offset within the word.
  // Anything that spills past lane 3 is dropped.
  logic [1:0]        wr_off;
  logic [DATA_W-1:0] wdata_steer;
  logic [3:0]        wstrb_steer;
  assign wr_off      = lsu_awaddr[1:0];
  assign wdata_steer = lsu_wdata << {wr_off, 3'b000};
  assign wstrb_steer = lsu_wstrb[3:0] << wr_off;

  // Misalignment detection (only meaningful when the check is built in)
  logic rd_misalign;
  logic wr_misalign;
`ifdef YSYX_LSU_BRIDGE_ALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [2:0] size,
                                         input logic [1:0] off);
    logic bad;
    case (size)
      3'd0:    bad = 1'b0;
      3'd1:    bad = off[0];
      default: bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

  assign rd_misalign = is_misaligned(rd_size, lsu_araddr[1:0]);
  assign wr_misalign = is_misaligned(wr_size, wr_off);
`else
  assign rd_misalign = 1'b0;
  assign wr_misalign = 1'b0;
`endif

  // Single FSM. Every output is a register that is updated on the transition
  // that enters the state where the output must be visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      lsu_rdata  <= '0;
      lsu_rvalid <= 1'b0;
      lsu_wready <= 1'b0;
      lsu_err    <= 1'b0;
      araddr     <= '0;
      arsize     <= 3'd0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= '0;
      awsize     <= 3'd0;
      awvalid    <= 1'b0;
      wdata      <= '0;
      wstrb      <= 4'd0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (lsu_arvalid) begin
            if (rd_misalign) begin
              // Rejected without a bus cycle; complete immediately.
              lsu_rdata  <= '0;
              lsu_rvalid <= 1'b1;
              lsu_err    <= 1'b1;
              state_reg  <= RESP;
            end else begin
              araddr    <= lsu_araddr;
              arsize    <= rd_size;
              arvalid   <= 1'b1;
              state_reg <= RD_A;
            end
          end else if (lsu_awvalid && lsu_wvalid) begin
            if (wr_misalign) begin
              lsu_wready <= 1'b1;
              lsu_err    <= 1'b1;
              state_reg  <= RESP;
            end else begin
              awaddr    <= lsu_awaddr;
              awsize    <= wr_size;
              wdata     <= wdata_steer;
              wstrb     <= wstrb_steer;
              awvalid   <= 1'b1;
              wvalid    <= 1'b1;
              state_reg <= WR_A;
            end
          end
        end

        RD_A: begin
          if (arready) begin
            arvalid   <= 1'b0;
            rready    <= 1'b1;
            state_reg <= RD_D;
          end
        end

        RD_D: begin
          if (rvalid) begin
            rready     <= 1'b0;
            lsu_rdata  <= rdata;
            lsu_err    <= (rresp != 2'b00);
            lsu_rvalid <= 1'b1;
            state_reg  <= RESP;
          end
        end

        WR_A: begin
          // AW and W retire independently.
          // A channel whose valid is already low has finished its handshake.
          if (awvalid && awready) begin
            awvalid <= 1'b0;
          end
          if (wvalid && wready) begin
            wvalid <= 1'b0;
          end
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready    <= 1'b1;
            state_reg <= WR_B;
          end
        end

        WR_B: begin
          if (bvalid) begin
            bready     <= 1'b0;
            lsu_err    <= (bresp != 2'b00);
            lsu_wready <= 1'b1;
            state_reg  <= RESP;
          end
        end

        RESP: begin
          // The pulse is visible for exactly this one cycle.
          // lsu_rdata keeps its value.
          lsu_rvalid <= 1'b0;
          lsu_wready <= 1'b0;
          lsu_err    <= 1'b0;
          state_reg  <= HOLD;
        end

        HOLD: begin
          // The LSU is still dropping its request here.
          // Ignore it so the request is not accepted a second time.
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_lsu_bus_bridge.sv
module tb_ysyx_lsu_bus_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] lsu_araddr;
  logic        lsu_arvalid;
  logic [7:0]  lsu_rstrb;
  logic [31:0] lsu_awaddr;
  logic        lsu_awvalid;
  logic        lsu_wvalid;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wstrb;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic        lsu_wready;
  logic        lsu_err;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  ysyx_lsu_bus_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wvalid(lsu_wvalid),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid), .lsu_wready(lsu_wready),
    .lsu_err(lsu_err),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake and pulse counters
  int ar_hs = 0;
  int aw_hs = 0;
  int w_hs = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  always @(posedge clk) begin
    if (arvalid && arready) ar_hs <= ar_hs + 1;
    if (awvalid && awready) aw_hs <= aw_hs + 1;
    if (wvalid && wready)   w_hs <= w_hs + 1;
    if (lsu_rvalid)         rd_pulses <= rd_pulses + 1;
    if (lsu_wready)         wr_pulses <= wr_pulses + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [7:0]  strb;
    logic [31:0] wd;
    logic [31:0] bus_rdata;
    logic [1:0]  resp;
    logic [2:0]  exp_size;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  int ar0, aw0, w0, p0;

  initial begin
    // is_wr addr strb wd bus_rdata resp size wstrb wdata err
    vecs[0] = '{1'b0, 32'h8000_0004, 8'h0f, 32'h0, 32'hDEAD_BEEF, 2'b00, 3'd2, 4'h0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h8000_0001, 8'h01, 32'h0, 32'h1122_3344, 2'b00, 3'd0, 4'h0, 32'h0, 1'b0};
    vecs[2] = '{1'b0, 32'h8000_0002, 8'h03, 32'h0, 32'hCAFE_F00D, 2'b01, 3'd1, 4'h0, 32'h0, 1'b1};
    vecs[3] = '{1'b1, 32'h8000_0003, 8'h01, 32'h0000_00AB, 32'h0, 2'b00, 3'd0, 4'b1000, 32'hAB00_0000, 1'b0};
    vecs[4] = '{1'b1, 32'h8000_0002, 8'h03, 32'h0000_1234, 32'h0, 2'b00, 3'd1, 4'b1100, 32'h1234_0000, 1'b0};
    vecs[5] = '{1'b1, 32'h8000_0000, 8'h0f, 32'h89AB_CDEF, 32'h0, 2'b11, 3'd2, 4'b1111, 32'h89AB_CDEF, 1'b1};
    vecs[6] = '{1'b1, 32'h8000_0000, 8'h07, 32'h00FF_EEDD, 32'h0, 2'b00, 3'd2, 4'b0111, 32'h00FF_EEDD, 1'b0};
    vecs[7] = '{1'b1, 32'h8000_0001, 8'h01, 32'h0000_005A, 32'h0, 2'b00, 3'd0, 4'b0010, 32'h0000_5A00, 1'b0};

    rst = 1'b1;
    lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rstrb = 8'h0;
    lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    lsu_wdata = '0; lsu_wstrb = 8'h0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_bready", 32'(bready), 32'd0);
    check("rst_pulses", 32'({lsu_rvalid, lsu_wready, lsu_err}), 32'd0);
    check("rst_lsu_rdata", lsu_rdata, 32'd0);

    // Table-driven minimum-latency transactions
    for (int i = 0; i < 8; i++) begin
      arready = 1'b1; rvalid = 1'b1; rdata = vecs[i].bus_rdata; rresp = vecs[i].resp;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = vecs[i].resp;
      if (!vecs[i].is_wr) begin
        lsu_araddr = vecs[i].addr; lsu_rstrb = vecs[i].strb; lsu_arvalid = 1'b1;
      end else begin
        lsu_awaddr = vecs[i].addr; lsu_wstrb = vecs[i].strb; lsu_wdata = vecs[i].wd;
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
      end
      step(); // N+1
      if (!vecs[i].is_wr) begin
        check($sformatf("v%0d_arvalid", i), 32'(arvalid), 32'd1);
        check($sformatf("v%0d_araddr", i), araddr, vecs[i].addr);
        check($sformatf("v%0d_arsize", i), 32'(arsize), 32'(vecs[i].exp_size));
      end else begin
        check($sformatf("v%0d_aw_w_valid", i), 32'({awvalid, wvalid}), 32'd3);
        check($sformatf("v%0d_awaddr", i), awaddr, vecs[i].addr);
        check($sformatf("v%0d_awsize", i), 32'(awsize), 32'(vecs[i].exp_size));
        check($sformatf("v%0d_wstrb", i), 32'(wstrb), 32'(vecs[i].exp_wstrb));
        check($sformatf("v%0d_wdata", i), wdata, vecs[i].exp_wdata);
      end
      step(); // N+2
      if (!vecs[i].is_wr) begin
        check($sformatf("v%0d_rready", i), 32'({arvalid, rready}), 32'd1);
      end else begin
        check($sformatf("v%0d_bready", i), 32'({awvalid, wvalid, bready}), 32'd1);
      end
      step(); // N+3
      if (!vecs[i].is_wr) begin
        check($sformatf("v%0d_lsu_rvalid", i), 32'({lsu_rvalid, lsu_wready}), 32'b10);
        check($sformatf("v%0d_lsu_rdata", i), lsu_rdata, vecs[i].bus_rdata);
      end else begin
        check($sformatf("v%0d_lsu_wready", i), 32'({lsu_rvalid, lsu_wready}), 32'b01);
      end
      check($sformatf("v%0d_lsu_err", i), 32'(lsu_err), 32'(vecs[i].exp_err));
      step(); // HOLD
      check($sformatf("v%0d_pulse_end", i), 32'({lsu_rvalid, lsu_wready, lsu_err}), 32'd0);
      lsu_arvalid = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
      step(); // IDLE
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      $display("txn %0d: %s addr=%h strb=%h done", i, vecs[i].is_wr ? "store" : "load",
               vecs[i].addr, vecs[i].strb);
    end

    // Store halfword with AW granted 3 cycles after W
    aw0 = aw_hs; w0 = w_hs; p0 = wr_pulses;
    awready = 1'b0; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
    lsu_awaddr = 32'h8000_0002; lsu_wdata = 32'h0000_1234; lsu_wstrb = 8'h03;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    step(); // N+1
    check("stag_valids", 32'({awvalid, wvalid}), 32'd3);
    check("stag_wstrb", 32'(wstrb), 32'b1100);
    check("stag_wdata", wdata, 32'h1234_0000);
    for (int k = 0; k < 3; k++) begin
      step(); // N+2..N+4
      check($sformatf("stag_wait%0d", k), 32'({awvalid, wvalid, bready}), 32'b100);
      check($sformatf("stag_awaddr%0d", k), awaddr, 32'h8000_0002);
    end
    awready = 1'b1;
    step(); // N+5
    check("stag_bready", 32'({awvalid, wvalid, bready}), 32'b001);
    awready = 1'b0; bvalid = 1'b1;
    step(); // N+6
    check("stag_lsu_wready", 32'({lsu_wready, lsu_err}), 32'b10);
    bvalid = 1'b0;
    step();
    check("stag_pulse_end", 32'(lsu_wready), 32'd0);
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    step();
    check("stag_aw_once", 32'(aw_hs - aw0), 32'd1);
    check("stag_w_once", 32'(w_hs - w0), 32'd1);
    check("stag_one_pulse", 32'(wr_pulses - p0), 32'd1);
    wready = 1'b0;
    $display("txn stagger: store half at 80000002 done");

    // Read with error response after a 5-cycle rvalid delay
    arready = 1'b1; rvalid = 1'b0; rresp = 2'b10; rdata = 32'h0BAD_F00D;
    lsu_araddr = 32'h8000_0010; lsu_rstrb = 8'h0f; lsu_arvalid = 1'b1;
    step(); // N+1
    check("dly_arvalid", 32'(arvalid), 32'd1);
    step(); // N+2
    for (int k = 0; k < 5; k++) begin
      check($sformatf("dly_rready%0d", k), 32'({rready, lsu_rvalid}), 32'b10);
      step();
    end
    check("dly_rready_last", 32'(rready), 32'd1);
    rvalid = 1'b1;
    step();
    check("dly_rvalid_err", 32'({lsu_rvalid, lsu_err}), 32'b11);
    check("dly_rdata", lsu_rdata, 32'h0BAD_F00D);
    rvalid = 1'b0; rresp = 2'b00;
    step();
    lsu_arvalid = 1'b0;
    step();
    $display("txn delayed: load with rresp=2 done");

    // Request held through RESP and HOLD
    ar0 = ar_hs; p0 = rd_pulses;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h1357_9BDF;
    lsu_araddr = 32'h8000_0020; lsu_rstrb = 8'h0f; lsu_arvalid = 1'b1;
    step(); step(); step(); // N+3
    check("held_pulse", 32'(lsu_rvalid), 32'd1);
    step(); // HOLD
    check("held_hold_arvalid", 32'(arvalid), 32'd0);
    step(); // IDLE
    check("held_idle_arvalid", 32'(arvalid), 32'd0);
    check("held_one_ar", 32'(ar_hs - ar0), 32'd1);
    check("held_one_pulse", 32'(rd_pulses - p0), 32'd1);
    step(); // re-accepted in IDLE
    check("held_reaccept", 32'(arvalid), 32'd1);
    lsu_arvalid = 1'b0;
    step(); step(); // pulse
    check("held_second_pulse", 32'(lsu_rvalid), 32'd1);
    step(); step();
    check("held_two_ar", 32'(ar_hs - ar0), 32'd2);
    arready = 1'b0; rvalid = 1'b0;
    $display("txn held: load held through RESP/HOLD done");

`ifdef YSYX_LSU_BRIDGE_ALIGN_CHECK_EN
    // Misaligned word load is rejected without a bus cycle
    ar0 = ar_hs;
    arready = 1'b1; rvalid = 1'b1;
    lsu_araddr = 32'h8000_0002; lsu_rstrb = 8'h0f; lsu_arvalid = 1'b1;
    step(); // N+1
    check("mis_pulse_err", 32'({lsu_rvalid, lsu_err}), 32'b11);
    check("mis_rdata", lsu_rdata, 32'd0);
    check("mis_arvalid", 32'(arvalid), 32'd0);
    lsu_arvalid = 1'b0;
    step(); step();
    check("mis_no_ar", 32'(ar_hs - ar0), 32'd0);
    arready = 1'b0; rvalid = 1'b0;
    $display("txn misaligned: load word at 80000002 done");
`endif

    // Reset while in RD_D
    p0 = rd_pulses;
    arready = 1'b1; rvalid = 1'b0; rdata = 32'hFFFF_0000;
    lsu_araddr = 32'h8000_0030; lsu_rstrb = 8'h0f; lsu_arvalid = 1'b1;
    step(); step(); // RD_D
    check("rstmid_rready", 32'(rready), 32'd1);
    rst = 1'b1; lsu_arvalid = 1'b0;
    step();
    check("rstmid_ready_valid", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
    check("rstmid_lsu_out", 32'({lsu_rvalid, lsu_wready, lsu_err}), 32'd0);
    check("rstmid_rdata", lsu_rdata, 32'd0);
    rst = 1'b0; rvalid = 1'b1;
    step(); step(); step();
    check("rstmid_no_pulse", 32'(rd_pulses - p0), 32'd0);
    check("rstmid_idle", 32'({arvalid, rready}), 32'd0);
    rvalid = 1'b0; arready = 1'b0;
    $display("txn reset: load abandoned in RD_D");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
